load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// RV32I load/store unit sitting between the execute stage and a simple
// request/acknowledge data memory. A request is accepted in IDLE, checked for
// legality and alignment, formatted into a word-aligned memory access with
// byte strobes and lane-replicated write data, and then waits for mem_ack
// (bounded by TIMEOUT cycles). The result (extracted/extended load data, or an
// error flag) is reported by a one-cycle resp_valid pulse.
//
// Parameters
//   TIMEOUT     maximum WAIT_ACK cycles before the access is aborted
//
// Ports
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous active-high reset
//   req_valid   in   1   execute stage presents a load or store
//   req_ready   out  1   unit can accept a request (IDLE only)
//   req_we      in   1   1 = store, 0 = load
//   req_funct3  in   3   RV32I width/sign code
//   alu_addr    in   32  byte address
//   store_data  in   32  rs2 value
//   mem_req     out  1   memory request, held until ack or timeout
//   mem_we      out  1   write enable qualifying mem_req
//   mem_addr    out  32  word-aligned address
//   mem_wdata   out  32  lane-replicated store data
//   mem_wstrb   out  4   byte-lane write strobes
//   mem_rdata   in   32  read word, valid with mem_ack
//   mem_ack     in   1   one-cycle completion from memory
//   resp_valid  out  1   one-cycle result/error pulse
//   load_data   out  32  extracted load result
//   err         out  1   misaligned / illegal / timeout flag
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] alu_addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        err
);

    // Counter only needs to reach TIMEOUT-1: the timeout decision is taken
    // on the last counted cycle itself.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RESP     = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_req_ready;
    logic              w_req_ready_nxt;
    logic              r_mem_req;
    logic              w_mem_req_nxt;
    logic              r_mem_we;
    logic              w_mem_we_nxt;
    logic [31:0]       r_mem_addr;
    logic [31:0]       w_mem_addr_nxt;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       w_mem_wdata_nxt;
    logic [3:0]        r_mem_wstrb;
    logic [3:0]        w_mem_wstrb_nxt;
    logic              r_resp_valid;
    logic              w_resp_valid_nxt;
    logic [31:0]       r_load_data;
    logic [31:0]       w_load_data_nxt;
    logic              r_err;
    logic              w_err_nxt;
    // Request attributes kept for load extraction after the ack
    logic [2:0]        r_funct3;
    logic [2:0]        w_funct3_nxt;
    logic [1:0]        r_addr_lo;
    logic [1:0]        w_addr_lo_nxt;
    logic              r_we;
    logic              w_we_nxt;

    logic              w_illegal;
    logic              w_misaligned;
    logic [3:0]        w_st_wstrb;
    logic [31:0]       w_st_wdata;
    logic [7:0]        w_lane_byte;
    logic [15:0]       w_lane_half;
    logic [31:0]       w_load_ext;

    // Request decode: legality, alignment and store lane formatting
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_st_wstrb   = 4'b0000;
        w_st_wdata   = 32'h0000_0000;
        case (req_funct3)
            3'b000: begin
                w_st_wstrb = 4'b0001 << alu_addr[1:0];
                w_st_wdata = {4{store_data[7:0]}};
            end
            3'b001: begin
                w_misaligned = alu_addr[0];
                w_st_wstrb   = 4'b0011 << alu_addr[1:0];
                w_st_wdata   = {2{store_data[15:0]}};
            end
            3'b010: begin
                w_misaligned = (alu_addr[1:0] != 2'b00);
                w_st_wstrb   = 4'b1111;
                w_st_wdata   = store_data;
            end
            // Unsigned widths exist only for loads
            3'b100: begin
                w_illegal = req_we;
            end
            3'b101: begin
                w_illegal    = req_we;
                w_misaligned = alu_addr[0];
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Load extraction: pick the addressed lane of the read word and extend it
    always_comb begin
        w_lane_byte = 8'h00;
        w_lane_half = 16'h0000;
        w_load_ext  = 32'h0000_0000;
        case (r_addr_lo)
            2'b00:   w_lane_byte = mem_rdata[7:0];
            2'b01:   w_lane_byte = mem_rdata[15:8];
            2'b10:   w_lane_byte = mem_rdata[23:16];
            2'b11:   w_lane_byte = mem_rdata[31:24];
            default: w_lane_byte = mem_rdata[7:0];
        endcase
        w_lane_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_lane_byte[7]}}, w_lane_byte};
            3'b100:  w_load_ext = {24'h00_0000, w_lane_byte};
            3'b001:  w_load_ext = {{16{w_lane_half[15]}}, w_lane_half};
            3'b101:  w_load_ext = {16'h0000, w_lane_half};
            3'b010:  w_load_ext = mem_rdata;
            default: w_load_ext = 32'h0000_0000;
        endcase
    end

    // Next-state and next-output logic of the access FSM
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_wstrb_nxt  = r_mem_wstrb;
        w_resp_valid_nxt = 1'b0;
        w_load_data_nxt  = r_load_data;
        w_err_nxt        = r_err;
        w_funct3_nxt     = r_funct3;
        w_addr_lo_nxt    = r_addr_lo;
        w_we_nxt         = r_we;
        case (r_state)
            IDLE: begin
                w_mem_req_nxt   = 1'b0;
                w_load_data_nxt = 32'h0000_0000;
                w_err_nxt       = 1'b0;
                if (req_valid) begin
                    w_funct3_nxt  = req_funct3;
                    w_addr_lo_nxt = alu_addr[1:0];
                    w_we_nxt      = req_we;
                    if (w_illegal || w_misaligned) begin
                        // Rejected without touching memory
                        w_state_nxt      = RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_err_nxt        = 1'b1;
                    end else begin
                        w_state_nxt     = WAIT_ACK;
                        w_cnt_nxt       = {CNT_W{1'b0}};
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = req_we;
                        w_mem_addr_nxt  = {alu_addr[31:2], 2'b00};
                        w_mem_wdata_nxt = req_we ? w_st_wdata : 32'h0000_0000;
                        w_mem_wstrb_nxt = req_we ? w_st_wstrb : 4'b0000;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_ACK: begin
                if (mem_ack) begin
                    // An ack on the last counted cycle still completes normally
                    w_state_nxt      = RESP;
                    w_mem_req_nxt    = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_err_nxt        = 1'b0;
                    w_load_data_nxt  = r_we ? 32'h0000_0000 : w_load_ext;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt      = RESP;
                    w_mem_req_nxt    = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_err_nxt        = 1'b1;
                    w_load_data_nxt  = 32'h0000_0000;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                w_state_nxt     = IDLE;
                w_mem_req_nxt   = 1'b0;
                w_load_data_nxt = 32'h0000_0000;
                w_err_nxt       = 1'b0;
            end
            default: begin
                w_state_nxt     = IDLE;
                w_mem_req_nxt   = 1'b0;
                w_load_data_nxt = 32'h0000_0000;
                w_err_nxt       = 1'b0;
            end
        endcase
        w_req_ready_nxt = (w_state_nxt == IDLE);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_req_ready  <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_mem_wstrb  <= 4'b0000;
            r_resp_valid <= 1'b0;
            r_load_data  <= 32'h0000_0000;
            r_err        <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_we         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_wstrb  <= w_mem_wstrb_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_load_data  <= w_load_data_nxt;
            r_err        <= w_err_nxt;
            r_funct3     <= w_funct3_nxt;
            r_addr_lo    <= w_addr_lo_nxt;
            r_we         <= w_we_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;
    assign resp_valid = r_resp_valid;
    assign load_data  = r_load_data;
    assign err        = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for load_store_unit. Each access pushes its
// expected response onto a scoreboard queue; the entry is popped and compared
// when resp_valid is seen. Inputs are driven and outputs sampled on negedges.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] alu_addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        err;

    typedef struct packed {
        logic [31:0] ld;
        logic        er;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .alu_addr   (alu_addr),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .resp_valid (resp_valid),
        .load_data  (load_data),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called on a negedge in IDLE; returns on the negedge of the first IDLE
    // cycle after the response, so the next call is back-to-back.
    // ack_at: WAIT_ACK cycle (1-based) in which mem_ack is driven, 0 = never.
    task automatic run_access(
        input string       tag,
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] sd,
        input logic [31:0] rdata,
        input int          ack_at,
        input logic        exp_req,
        input logic [31:0] exp_maddr,
        input logic [3:0]  exp_strb,
        input logic [31:0] exp_wdata,
        input logic [31:0] exp_ld,
        input logic        exp_err
    );
        exp_t        e;
        int          k;
        int          req_cycles;
        int          exp_lat;
        int          exp_reqc;
        logic        stable_bad;
        logic [68:0] snap;

        chk({tag, "_ready_in"}, 32'(req_ready), 32'd1);
        e.ld = exp_ld;
        e.er = exp_err;
        sb_q.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        alu_addr   = addr;
        store_data = sd;
        @(negedge clk);
        // Scramble the request fields: the unit must use its latched copy
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'($urandom);
        alu_addr   = $urandom;
        store_data = $urandom;
        if (exp_req) begin
            chk({tag, "_mem_req"},   32'(mem_req),   32'd1);
            chk({tag, "_mem_we"},    32'(mem_we),    32'(we));
            chk({tag, "_mem_addr"},  mem_addr,       exp_maddr);
            chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
            chk({tag, "_mem_wdata"}, mem_wdata,      exp_wdata);
        end else begin
            chk({tag, "_no_req"},    32'(mem_req),   32'd0);
        end
        snap       = {mem_we, mem_wstrb, mem_addr, mem_wdata};
        k          = 1;
        req_cycles = 0;
        stable_bad = 1'b0;
        while (resp_valid !== 1'b1 && k <= 3 * TO) begin
            if (mem_req === 1'b1) begin
                req_cycles++;
                if ({mem_we, mem_wstrb, mem_addr, mem_wdata} !== snap) stable_bad = 1'b1;
                if (req_ready !== 1'b0) stable_bad = 1'b1;
            end
            if (k == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            k++;
        end
        if (!exp_req) begin
            exp_lat  = 1;
            exp_reqc = 0;
        end else if (ack_at >= 1 && ack_at <= TO) begin
            exp_lat  = ack_at + 1;
            exp_reqc = ack_at;
        end else begin
            exp_lat  = TO + 1;
            exp_reqc = TO;
        end
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_latency"},    32'(k),          32'(exp_lat));
        chk({tag, "_req_cycles"}, 32'(req_cycles), 32'(exp_reqc));
        chk({tag, "_stable"},     32'(stable_bad), 32'd0);
        chk({tag, "_req_drop"},   32'(mem_req),    32'd0);
        chk({tag, "_ready_resp"}, 32'(req_ready),  32'd0);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_load_data"}, load_data, e.ld);
            chk({tag, "_err"},       32'(err),  32'(e.er));
        end
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        chk({tag, "_ready_out"}, 32'(req_ready),  32'd1);
    endtask

    initial begin
        logic seen;
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        alu_addr   = 32'h0000_0000;
        store_data = 32'h0000_0000;
        mem_rdata  = 32'h0000_0000;
        mem_ack    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req",    32'(mem_req),    32'd0);
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_mem_wstrb",  32'(mem_wstrb),  32'd0);
        chk("rst_mem_addr",   mem_addr,        32'd0);
        chk("rst_mem_wdata",  mem_wdata,       32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_load_data",  load_data,       32'd0);
        chk("rst_err",        32'(err),        32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready",  32'(req_ready),  32'd1);

        //          tag     we    f3      addr          store_data    rdata         ack req maddr         strb     wdata         load_data     err
        run_access("lb",    1'b0, 3'b000, 32'h0000_1003, 32'h0,       32'h80AA_BBCC, 2, 1'b1, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0);
        run_access("sh",    1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,      1, 1'b1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
        run_access("lw_mis",1'b0, 3'b010, 32'h0000_3001, 32'h0,       32'h0,         1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,         1'b1);
        run_access("lh",    1'b0, 3'b001, 32'h0000_0402, 32'h0,       32'h8001_1234, 3, 1'b1, 32'h0000_0400, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0);
        run_access("lbu",   1'b0, 3'b100, 32'h0000_0501, 32'h0,       32'h1234_FF56, 1, 1'b1, 32'h0000_0500, 4'b0000, 32'h0,        32'h0000_00FF, 1'b0);
        run_access("lhu",   1'b0, 3'b101, 32'h0000_0602, 32'h0,       32'h8001_1234, 2, 1'b1, 32'h0000_0600, 4'b0000, 32'h0,        32'h0000_8001, 1'b0);
        run_access("lw",    1'b0, 3'b010, 32'h0000_0700, 32'h0,       32'hDEAD_BEEF, 1, 1'b1, 32'h0000_0700, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0);
        run_access("sb",    1'b1, 3'b000, 32'h0000_0803, 32'hAABB_CC55, 32'h0,      1, 1'b1, 32'h0000_0800, 4'b1000, 32'h5555_5555, 32'h0,        1'b0);
        run_access("sw",    1'b1, 3'b010, 32'h0000_0904, 32'hCAFE_F00D, 32'h0,      4, 1'b1, 32'h0000_0904, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0);
        run_access("lhu_to",1'b0, 3'b101, 32'h0000_0A00, 32'h0,       32'h0,         0, 1'b1, 32'h0000_0A00, 4'b0000, 32'h0,        32'h0,         1'b1);
        run_access("lb_last",1'b0,3'b000, 32'h0000_0B00, 32'h0,       32'h0000_007F, TO, 1'b1, 32'h0000_0B00, 4'b0000, 32'h0,       32'h0000_007F, 1'b0);
        run_access("ld_ill",1'b0, 3'b011, 32'h0000_0C00, 32'h0,       32'h0,         1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,         1'b1);
        run_access("st_ill",1'b1, 3'b100, 32'h0000_0C04, 32'h0,       32'h0,         1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,         1'b1);
        run_access("sh_mis",1'b1, 3'b001, 32'h0000_0C01, 32'h1111_2222, 32'h0,      1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,         1'b1);

        // Stray ack while idle must be ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_req",   32'(mem_req),    32'd0);
        @(negedge clk);
        chk("idle_ack_resp",  32'(resp_valid), 32'd0);
        chk("idle_ack_ready", 32'(req_ready),  32'd1);

        // Reset in WAIT_ACK abandons the access; a later ack is ignored
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b101;
        alu_addr   = 32'h0000_0E00;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rwait_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rwait_req_drop", 32'(mem_req),    32'd0);
        chk("rwait_addr",     mem_addr,        32'd0);
        chk("rwait_resp",     32'(resp_valid), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        seen      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) seen = 1'b1;
        end
        chk("rwait_no_resp", 32'(seen),      32'd0);
        chk("rwait_ready",   32'(req_ready), 32'd1);

        // Unit recovers normally after the abandoned access
        run_access("lw_post", 1'b0, 3'b010, 32'h0000_0F08, 32'h0, 32'h0BAD_F00D, 1, 1'b1, 32'h0000_0F08, 4'b0000, 32'h0, 32'h0BAD_F00D, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
